// File: rtl/iu_pkg.sv
// iu_pkg: shared op type, port FSM states and default widths for the IU memory port.
package iu_pkg;
    localparam int IU_ADDR_W      = 16;
    localparam int IU_DATA_W      = 32;
    localparam int IU_TAG_W       = 4;
    localparam int IU_QDEPTH      = 2;
    localparam int IU_TIMEOUT_CYC = 256;

    typedef struct packed {
        logic                 is_store;
        logic [IU_ADDR_W-1:0] addr;
        logic [IU_DATA_W-1:0] wdata;
        logic [IU_TAG_W-1:0]  tag;
    } iu_op_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} iu_port_state_e;
endpackage

// File: rtl/iu_op_fifo.sv
// iu_op_fifo: small synchronous FIFO of ops with asynchronous active-low reset.
module iu_op_fifo
    import iu_pkg::*;
#(
    parameter type T     = iu_op_t,
    parameter int  DEPTH = IU_QDEPTH
) (
    input  logic clk,
    input  logic resetN,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic ready,
    output logic empty
);
    localparam int PW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("iu_op_fifo: DEPTH must be a power of 2 and at least 2");
    end

    T              mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0]   cnt;
    logic          wr, rd;

    assign wr    = push && ready;
    assign rd    = pop && !empty;
    assign ready = cnt != (PW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign dout  = mem[rp];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr) wp <= wp + PW'(1);
            if (rd) rp <= rp + PW'(1);
            cnt <= cnt + (PW+1)'(wr) - (PW+1)'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= din;
    end
endmodule

// File: rtl/iu_mem_port.sv
// iu_mem_port: IU-side initiator of iu_miu_if; queues ops and keeps one MIU transaction outstanding.
// Optional request watchdog is built when IU_REQ_TIMEOUT_EN is defined.
module iu_mem_port
    import iu_pkg::*;
#(
    parameter int ADDR_W      = IU_ADDR_W,
    parameter int DATA_W      = IU_DATA_W,
    parameter int TAG_W       = IU_TAG_W,
    parameter int QDEPTH      = IU_QDEPTH,
    parameter int TIMEOUT_CYC = IU_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              op_is_store,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    input  logic [TAG_W-1:0]  op_tag,
    output logic              miu_req,
    output logic              miu_we,
    output logic [ADDR_W-1:0] miu_addr,
    output logic [DATA_W-1:0] miu_wdata,
    input  logic              miu_gnt,
    input  logic              miu_done,
    input  logic [DATA_W-1:0] miu_rdata,
    output logic              wb_valid,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_err,
    output logic              busy
);
    typedef struct packed {
        logic              is_store;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [TAG_W-1:0]  tag;
    } op_t;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("iu_mem_port: TIMEOUT_CYC must be positive");
    end

    iu_port_state_e   state, state_nx;
    op_t              op_in, head;
    logic [TAG_W-1:0] tag_q;
    logic             empty, deq, fin, to_hit, ends;

    assign op_in = '{op_is_store, op_addr, op_wdata, op_tag};

    iu_op_fifo #(.T(op_t), .DEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .resetN(resetN),
        .push  (op_valid),
        .din   (op_in),
        .pop   (deq),
        .dout  (head),
        .ready (op_ready),
        .empty (empty)
    );

    assign deq      = state == IDLE && !empty;
    // gnt and done together in REQ complete the transaction in a single step
    assign fin      = miu_done && (state == WAIT || (state == REQ && miu_gnt));
    assign ends     = fin || to_hit;
    assign miu_req  = state == REQ;
    assign wb_valid = state == RESP;
    assign busy     = !empty || state != IDLE;

`ifdef IU_REQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] to_cnt;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) to_cnt <= '0;
        else if (state == IDLE) to_cnt <= '0;
        else if (state != RESP) to_cnt <= to_cnt + CW'(1);
    end
    assign to_hit = (state == REQ || state == WAIT) && to_cnt == CW'(TIMEOUT_CYC - 1);
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = empty ? IDLE : REQ;
            REQ, WAIT: state_nx = ends ? (miu_we ? IDLE : RESP) : (state == REQ && miu_gnt) ? WAIT : state;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            miu_we    <= 1'b0;
            miu_addr  <= '0;
            miu_wdata <= '0;
            tag_q     <= '0;
            wb_tag    <= '0;
            wb_data   <= '0;
            wb_err    <= 1'b0;
        end else begin
            if (deq) begin
                miu_we    <= head.is_store;
                miu_addr  <= head.addr;
                miu_wdata <= head.wdata;
                tag_q     <= head.tag;
            end
            // a watchdog abort returns zero data flagged as an error
            if (ends && !miu_we) begin
                wb_tag  <= tag_q;
                wb_data <= fin ? miu_rdata : '0;
                wb_err  <= !fin;
            end
        end
    end
endmodule
